wt_mem_req_arbiter: RTL and testbench

Shares the single cache-to-memory request port between the instruction cache (requester 0) and the write-through data cache (requester 1). It grants with round-robin and allocates a transaction ID (TID) from a pool of 2**MemTidWidth entries. It routes each memory response back to its owner by TID. It sits between the cache subsystem and the AXI adapter, and caps total outstanding transactions at the TID pool size (4 for MemTidWidth = 2).

---
 rtl/wt_mem_req_arbiter_if.sv | 47 ++++
 rtl/wt_mem_req_arbiter.sv | 121 ++++++++++++
 tb/tb_wt_mem_req_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wt_mem_req_arbiter_if.sv
// Cache-side request/response and memory-side port bundle of the write-through memory request arbiter.
// The slave modport is the arbiter's view; the master modport is the view of whoever drives it.
interface wt_mem_req_arbiter_if #(
  parameter int AddrWidth   = 64,
  parameter int DataWidth   = 64,
  parameter int MemTidWidth = 2
);
  logic [1:0]                 req_valid_i;
  logic [1:0]                 req_ready_o;
  logic [1:0][AddrWidth-1:0]  req_addr_i;
  logic [1:0]                 req_we_i;
  logic [1:0][DataWidth-1:0]  req_wdata_i;

  logic                       mem_req_valid_o;
  logic                       mem_req_ready_i;
  logic [AddrWidth-1:0]       mem_req_addr_o;
  logic                       mem_req_we_o;
  logic [DataWidth-1:0]       mem_req_wdata_o;
  logic [MemTidWidth-1:0]     mem_req_tid_o;

  logic                       mem_rsp_valid_i;
  logic [MemTidWidth-1:0]     mem_rsp_tid_i;
  logic [DataWidth-1:0]       mem_rsp_rdata_i;

  logic [1:0]                 rsp_valid_o;
  logic [DataWidth-1:0]       rsp_rdata_o;
  logic [MemTidWidth:0]       outstanding_o;
  logic                       tid_err_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i,
    output req_ready_o,
    output mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_tid_o,
    input  mem_req_ready_i,
    input  mem_rsp_valid_i, mem_rsp_tid_i, mem_rsp_rdata_i,
    output rsp_valid_o, rsp_rdata_o, outstanding_o, tid_err_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i,
    input  req_ready_o,
    input  mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_tid_o,
    output mem_req_ready_i,
    output mem_rsp_valid_i, mem_rsp_tid_i, mem_rsp_rdata_i,
    input  rsp_valid_o, rsp_rdata_o, outstanding_o, tid_err_o
  );
endinterface

// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request port between icache (0) and dcache (1),
// allocating TIDs from a small pool and steering responses back to the owning requester.
module wt_mem_req_arbiter #(
  parameter int AddrWidth   = 64,
  parameter int DataWidth   = 64,
  parameter int MemTidWidth = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  wt_mem_req_arbiter_if.slave   bus
);
  localparam int NrTid = 2**MemTidWidth;

  logic [NrTid-1:0]       w_busy;
  logic [NrTid-1:0]       w_owner;
  logic                   r_rr_ptr;
  logic                   r_mem_valid;
  logic [AddrWidth-1:0]   r_mem_addr;
  logic                   r_mem_we;
  logic [DataWidth-1:0]   r_mem_wdata;
  logic [MemTidWidth-1:0] r_mem_tid;
  logic                   r_tid_err;

  logic                   w_free_found;
  logic [MemTidWidth-1:0] w_free_tid;
  logic                   w_win_valid;
  logic                   w_winner;
  logic                   w_out_space;
  logic                   w_grant;
  logic                   w_rsp_busy;
  logic                   w_rsp_owner;
  logic                   w_rsp_hit;
  logic [MemTidWidth:0]   w_outstanding;

  // Lowest-index free TID, looked up on the busy bits registered at cycle start
  always_comb begin
    w_free_found = 1'b0;
    w_free_tid   = '0;
    for (int i = NrTid - 1; i >= 0; i--) begin
      if (!w_busy[i]) begin
        w_free_found = 1'b1;
        w_free_tid   = MemTidWidth'(i);
      end
    end
  end

  always_comb begin
    w_win_valid = |bus.req_valid_i;
    if (bus.req_valid_i[r_rr_ptr]) w_winner = r_rr_ptr;
    else                           w_winner = ~r_rr_ptr;
  end

  // Gated by rst_ni so nothing is accepted while reset is held
  assign w_out_space     = !r_mem_valid || bus.mem_req_ready_i;
  assign w_grant         = rst_ni && w_win_valid && w_free_found && w_out_space;
  assign bus.req_ready_o = {w_grant && w_winner, w_grant && !w_winner};

  assign w_rsp_busy      = w_busy[bus.mem_rsp_tid_i];
  assign w_rsp_owner     = w_owner[bus.mem_rsp_tid_i];
  assign w_rsp_hit       = bus.mem_rsp_valid_i && w_rsp_busy;
  assign bus.rsp_valid_o = {w_rsp_hit && w_rsp_owner, w_rsp_hit && !w_rsp_owner};
  assign bus.rsp_rdata_o = bus.mem_rsp_rdata_i;

  // An allocated TID is never busy, so allocation and freeing never target the same entry
  for (genvar gi = 0; gi < NrTid; gi++) begin : g_tid
    logic r_busy;
    logic r_owner;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_busy  <= 1'b0;
        r_owner <= 1'b0;
      end else if (w_grant && (w_free_tid == MemTidWidth'(gi))) begin
        r_busy  <= 1'b1;
        r_owner <= w_winner;
      end else if (w_rsp_hit && (bus.mem_rsp_tid_i == MemTidWidth'(gi))) begin
        r_busy  <= 1'b0;
      end
    end
    assign w_busy[gi]  = r_busy;
    assign w_owner[gi] = r_owner;
  end

  always_comb begin
    w_outstanding = '0;
    for (int i = 0; i < NrTid; i++) begin
      w_outstanding = w_outstanding + {{MemTidWidth{1'b0}}, w_busy[i]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr    <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_tid   <= '0;
      r_tid_err   <= 1'b0;
    end else begin
      r_tid_err <= bus.mem_rsp_valid_i && !w_rsp_busy;
      if (w_grant) begin
        r_rr_ptr    <= ~w_winner;
        r_mem_valid <= 1'b1;
        r_mem_addr  <= bus.req_addr_i[w_winner];
        r_mem_we    <= bus.req_we_i[w_winner];
        r_mem_wdata <= bus.req_wdata_i[w_winner];
        r_mem_tid   <= w_free_tid;
      end else if (bus.mem_req_ready_i) begin
        r_mem_valid <= 1'b0;
      end
    end
  end

  assign bus.mem_req_valid_o = r_mem_valid;
  assign bus.mem_req_addr_o  = r_mem_addr;
  assign bus.mem_req_we_o    = r_mem_we;
  assign bus.mem_req_wdata_o = r_mem_wdata;
  assign bus.mem_req_tid_o   = r_mem_tid;
  assign bus.outstanding_o   = w_outstanding;
  assign bus.tid_err_o       = r_tid_err;
endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Directed and randomized bench for wt_mem_req_arbiter; every cycle is compared against
// a transaction-level model of the TID pool, round-robin order and output register.
module tb_wt_mem_req_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TW = 2;
  localparam int NT = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  wt_mem_req_arbiter_if #(.AddrWidth(AW), .DataWidth(DW), .MemTidWidth(TW)) bus ();

  wt_mem_req_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MemTidWidth(TW)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  // Reference model: pool of TIDs with owners, last winner, and the pending memory request
  bit            m_busy[NT];
  bit            m_owner[NT];
  int            m_last;
  bit            m_ov;
  logic [AW-1:0] m_oa;
  bit            m_owe;
  logic [DW-1:0] m_od;
  logic [TW-1:0] m_ot;
  bit            m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      m_busy[t]  = 1'b0;
      m_owner[t] = 1'b0;
    end
    m_last = 1;
    m_ov   = 1'b0;
    m_oa   = '0;
    m_owe  = 1'b0;
    m_od   = '0;
    m_ot   = '0;
    m_err  = 1'b0;
  endtask

  task automatic set_idle();
    bus.req_valid_i     = 2'b00;
    bus.req_addr_i      = '0;
    bus.req_we_i        = 2'b00;
    bus.req_wdata_i     = '0;
    bus.mem_req_ready_i = 1'b1;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_tid_i   = '0;
    bus.mem_rsp_rdata_i = '0;
  endtask

  // Check all outputs against the model for the current inputs, advance the model, then one clock
  task automatic cycle();
    int win, fr, cnt, r;
    logic [1:0] er, ersp;
    logic [TW-1:0] rt;
    #1;
    rt  = bus.mem_rsp_tid_i;
    win = -1;
    for (int k = 1; k <= 2; k++) begin
      r = (m_last + k) % 2;
      if (win < 0 && bus.req_valid_i[r]) win = r;
    end
    fr = -1;
    for (int t = NT - 1; t >= 0; t--) if (!m_busy[t]) fr = t;
    er = 2'b00;
    if (win >= 0 && fr >= 0 && (!m_ov || bus.mem_req_ready_i)) er[win] = 1'b1;
    ersp = 2'b00;
    if (bus.mem_rsp_valid_i && m_busy[rt]) ersp[m_owner[rt]] = 1'b1;
    cnt = 0;
    for (int t = 0; t < NT; t++) cnt += int'(m_busy[t]);

    chk("req_ready", bus.req_ready_o, er);
    chk("rsp_valid", bus.rsp_valid_o, ersp);
    chk("rsp_rdata", bus.rsp_rdata_o, bus.mem_rsp_rdata_i);
    chk("outstanding", bus.outstanding_o, cnt);
    chk("tid_err", bus.tid_err_o, m_err);
    chk("mem_valid", bus.mem_req_valid_o, m_ov);
    if (m_ov) begin
      chk("mem_addr", bus.mem_req_addr_o, m_oa);
      chk("mem_we", bus.mem_req_we_o, m_owe);
      chk("mem_wdata", bus.mem_req_wdata_o, m_od);
      chk("mem_tid", bus.mem_req_tid_o, m_ot);
    end

    m_err = bus.mem_rsp_valid_i && !m_busy[rt];
    if (bus.mem_rsp_valid_i && m_busy[rt]) m_busy[rt] = 1'b0;
    if (er != 2'b00) begin
      m_busy[fr]  = 1'b1;
      m_owner[fr] = win[0];
      m_last      = win;
      m_ov        = 1'b1;
      m_oa        = bus.req_addr_i[win];
      m_owe       = bus.req_we_i[win];
      m_od        = bus.req_wdata_i[win];
      m_ot        = TW'(fr);
      $display("txn t=%0t req%0d tid=%0d we=%0d addr=%h", $time, win, fr, m_owe, m_oa);
    end else if (bus.mem_req_ready_i) begin
      m_ov = 1'b0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset_async();
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("rst_outstanding", bus.outstanding_o, 0);
    chk("rst_mem_valid", bus.mem_req_valid_o, 0);
    chk("rst_req_ready", bus.req_ready_o, 0);
    chk("rst_tid_err", bus.tid_err_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic drain();
    set_idle();
    for (int t = 0; t < NT; t++) begin
      if (m_busy[t]) begin
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_tid_i   = TW'(t);
        bus.mem_rsp_rdata_i = {$urandom, $urandom};
        cycle();
      end
    end
    set_idle();
    cycle();
  endtask

  initial begin
    model_reset();
    set_idle();
    bus.req_valid_i = 2'b11;
    #1;
    chk("reset_req_ready", bus.req_ready_o, 2'b00);
    chk("reset_mem_valid", bus.mem_req_valid_o, 0);
    chk("reset_mem_addr", bus.mem_req_addr_o, 0);
    chk("reset_mem_tid", bus.mem_req_tid_o, 0);
    chk("reset_outstanding", bus.outstanding_o, 0);
    chk("reset_tid_err", bus.tid_err_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    set_idle();

    // Single icache read
    bus.req_valid_i   = 2'b01;
    bus.req_addr_i[0] = 64'h8000_0000;
    cycle();
    chk("t1_valid", bus.mem_req_valid_o, 1);
    chk("t1_tid", bus.mem_req_tid_o, 0);
    chk("t1_addr", bus.mem_req_addr_o, 64'h8000_0000);
    chk("t1_outst1", bus.outstanding_o, 1);
    set_idle();
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_tid_i   = 2'd0;
    bus.mem_rsp_rdata_i = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("t1_rsp", bus.rsp_valid_o, 2'b01);
    chk("t1_rdata", bus.rsp_rdata_o, 64'h0123_4567_89AB_CDEF);
    cycle();
    set_idle();
    #1;
    chk("t1_outst0", bus.outstanding_o, 0);
    cycle();

    // Both requesters always valid: alternate grants, fill pool, one bubble at exact full
    do_reset_async();
    set_idle();
    bus.req_valid_i   = 2'b11;
    bus.req_addr_i[0] = 64'h100;
    bus.req_addr_i[1] = 64'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_grant", bus.req_ready_o, (i % 2) ? 2'b10 : 2'b01);
      cycle();
      chk("t2_tid", bus.mem_req_tid_o, i);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t2_full", bus.req_ready_o, 2'b00);
      cycle();
    end
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_tid_i   = 2'd0;
    #1;
    chk("t2_free_same_cycle", bus.req_ready_o, 2'b00);
    cycle();
    bus.mem_rsp_valid_i = 1'b0;
    #1;
    chk("t2_after_free", bus.req_ready_o, 2'b01);
    cycle();
    chk("t2_realloc_tid", bus.mem_req_tid_o, 0);
    drain();

    // Memory back-pressure on a dcache write
    set_idle();
    bus.req_valid_i    = 2'b10;
    bus.req_we_i[1]    = 1'b1;
    bus.req_addr_i[1]  = 64'h1_0000;
    bus.req_wdata_i[1] = 64'hDEAD_BEEF;
    cycle();
    bus.mem_req_ready_i = 1'b0;
    bus.req_valid_i     = 2'b11;
    bus.req_addr_i[1]   = 64'h2_0000;
    bus.req_wdata_i[1]  = 64'h5555;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_ready_blocked", bus.req_ready_o, 2'b00);
      chk("t3_hold_wdata", bus.mem_req_wdata_o, 64'hDEAD_BEEF);
      chk("t3_hold_addr", bus.mem_req_addr_o, 64'h1_0000);
      chk("t3_hold_we", bus.mem_req_we_o, 1);
      cycle();
    end
    bus.mem_req_ready_i = 1'b1;
    bus.req_valid_i     = 2'b00;
    #1;
    chk("t3_still_valid", bus.mem_req_valid_o, 1);
    cycle();
    chk("t3_released", bus.mem_req_valid_o, 0);
    drain();

    // Out-of-order responses; last winner is the dcache so icache gets TIDs 0 and 2
    set_idle();
    bus.req_valid_i = 2'b11;
    for (int i = 0; i < 3; i++) cycle();
    set_idle();
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_tid_i   = 2'd2;
    #1;
    chk("t4_rsp_tid2", bus.rsp_valid_o, 2'b01);
    cycle();
    bus.mem_rsp_tid_i = 2'd0;
    #1;
    chk("t4_rsp_tid0", bus.rsp_valid_o, 2'b01);
    cycle();
    set_idle();
    bus.req_valid_i = 2'b01;
    cycle();
    chk("t4_realloc_low", bus.mem_req_tid_o, 0);
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_tid_i   = 2'd1;
    #1;
    chk("t4_rsp_tid1", bus.rsp_valid_o, 2'b10);
    cycle();
    chk("t4_realloc_next", bus.mem_req_tid_o, 2);
    drain();

    // Response on an unallocated TID
    set_idle();
    bus.req_valid_i = 2'b01;
    cycle();
    set_idle();
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_tid_i   = 2'd3;
    #1;
    chk("t5_no_strobe", bus.rsp_valid_o, 2'b00);
    cycle();
    set_idle();
    #1;
    chk("t5_err_pulse", bus.tid_err_o, 1);
    chk("t5_table_kept", bus.outstanding_o, 1);
    cycle();
    chk("t5_err_clear", bus.tid_err_o, 0);
    chk("t5_table_kept2", bus.outstanding_o, 1);
    drain();

    // Asynchronous reset with three TIDs outstanding
    set_idle();
    bus.req_valid_i = 2'b11;
    for (int i = 0; i < 3; i++) cycle();
    set_idle();
    #1;
    chk("t6_three_out", bus.outstanding_o, 3);
    do_reset_async();
    set_idle();
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_tid_i   = 2'd1;
    cycle();
    set_idle();
    bus.req_valid_i = 2'b01;
    #1;
    chk("t6_stale_rsp_err", bus.tid_err_o, 1);
    cycle();
    chk("t6_resume_tid0", bus.mem_req_tid_o, 0);
    drain();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int busy_list[$];
      set_idle();
      bus.req_valid_i     = 2'($urandom);
      bus.req_we_i        = 2'($urandom);
      bus.req_addr_i[0]   = {$urandom, $urandom};
      bus.req_addr_i[1]   = {$urandom, $urandom};
      bus.req_wdata_i[0]  = {$urandom, $urandom};
      bus.req_wdata_i[1]  = {$urandom, $urandom};
      bus.mem_req_ready_i = ($urandom_range(3) != 0);
      for (int t = 0; t < NT; t++) if (m_busy[t]) busy_list.push_back(t);
      if (busy_list.size() > 0 && $urandom_range(9) < 4) begin
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_tid_i   = TW'(busy_list[$urandom_range(busy_list.size() - 1)]);
      end else if ($urandom_range(19) == 0) begin
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_tid_i   = TW'($urandom);
      end
      bus.mem_rsp_rdata_i = {$urandom, $urandom};
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
